// File: rtl/alu_pkg.sv
// Shared types for the shared-adder scheduler: FSM state encoding and datapath width.
package alu_pkg;

  localparam int ADD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/adder32bit.sv
// Area-oriented ripple-carry adder: one full-adder cell per bit, no lookahead.
module adder32bit
  import alu_pkg::*;
(
  input  logic [ADD_W-1:0] i_a,
  input  logic [ADD_W-1:0] i_b,
  input  logic             i_cin,
  output logic [ADD_W-1:0] o_adder_out,
  output logic             o_carry_out
);

  always_comb begin : p_ripple
    logic v_c;
    o_adder_out = '0;
    v_c         = i_cin;
    for (int i = 0; i < ADD_W; i++) begin
      o_adder_out[i] = i_a[i] ^ i_b[i] ^ v_c;
      v_c            = (i_a[i] & i_b[i]) | (v_c & (i_a[i] ^ i_b[i]));
    end
    o_carry_out = v_c;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// above i_ptr, wrapping past NUM_REQ-1 back to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_idx,
  output logic               o_any_grant
);

  always_comb begin : p_search
    logic [ID_W-1:0] v_idx;
    o_grant     = '0;
    o_grant_idx = '0;
    o_any_grant = 1'b0;
    v_idx       = '0;
    // Walk from the farthest candidate down to i_ptr so the nearest one wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      v_idx = ID_W'((int'(i_ptr) + i) % NUM_REQ);
      if (i_req[v_idx]) begin
        o_grant        = '0;
        o_grant[v_idx] = 1'b1;
        o_grant_idx    = v_idx;
        o_any_grant    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Shares one adder32bit between NUM_REQ requesters with round-robin arbitration;
// one transaction in flight, result held on a single id-tagged response port.
module adder_rr_scheduler
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [ADD_W*NUM_REQ-1:0] req_a,
  input  logic [ADD_W*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ADD_W-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy,
  output state_t                   dbg_state,
  output logic [ID_W-1:0]          dbg_rr_ptr
);

  // Handshake: a transfer happens on a rising edge where valid && ready. Sources
  // hold valid and payload stable until that edge; valid never depends on ready.

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ID_W-1:0]        r_rr_ptr;
  logic [ID_W-1:0]        r_op_id;
  logic [ADD_W-1:0]       r_op_a;
  logic [ADD_W-1:0]       r_op_b;
  logic                   r_op_cin;
  logic                   r_rsp_valid;
  logic [ADD_W-1:0]       r_rsp_sum;
  logic                   r_rsp_cout;
  logic [ID_W-1:0]        r_rsp_id;

  logic [NUM_REQ-1:0]     w_grant;
  logic [ID_W-1:0]        w_grant_idx;
  logic                   w_any_grant;
  logic                   w_accept;
  logic [NUM_REQ-1:0]     w_req_ready;
  logic [ID_W-1:0]        w_ptr_nxt;
  logic [ADD_W-1:0]       w_add_sum;
  logic                   w_add_cout;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_req       (req_valid),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any_grant (w_any_grant)
  );

  adder32bit u_adder (
    .i_a         (r_op_a),
    .i_b         (r_op_b),
    .i_cin       (r_op_cin),
    .o_adder_out (w_add_sum),
    .o_carry_out (w_add_cout)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_req_ready = '0;
    case (r_state)
      IDLE: begin
        if (w_any_grant) begin
          w_accept    = 1'b1;
          w_req_ready = w_grant;
          w_state_nxt = EXEC;
        end
      end
      EXEC:    w_state_nxt = RESP;
      RESP: begin
        if (r_rsp_valid && rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_ptr_nxt = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_op_id     <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_op_cin    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= '0;
      r_rsp_cout  <= 1'b0;
      r_rsp_id    <= '0;
    end else begin
      if (w_accept) begin
        r_op_a   <= req_a[w_grant_idx*ADD_W +: ADD_W];
        r_op_b   <= req_b[w_grant_idx*ADD_W +: ADD_W];
        r_op_cin <= req_cin[w_grant_idx];
        r_op_id  <= w_grant_idx;
        r_rr_ptr <= w_ptr_nxt;
      end
      if (r_state == EXEC) begin
        r_rsp_sum   <= w_add_sum;
        r_rsp_cout  <= w_add_cout;
        r_rsp_id    <= r_op_id;
        r_rsp_valid <= 1'b1;
      end else if (r_state == RESP && r_rsp_valid && rsp_ready) begin
        // Payload stays put after the handshake; only valid drops.
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Gating with rst_n keeps ready low while reset is held even if requests are up.
  assign req_ready  = w_req_ready & {NUM_REQ{rst_n}};
  assign rsp_valid  = r_rsp_valid;
  assign rsp_sum    = r_rsp_sum;
  assign rsp_cout   = r_rsp_cout;
  assign rsp_id     = r_rsp_id;
  assign busy       = (r_state != IDLE);
  assign dbg_state  = r_state;
  assign dbg_rr_ptr = r_rr_ptr;

endmodule
